m_receiver: RTL and testbench

- Manchester line receiver and decoder: the receive end of the single-wire Manchester link driven by the transmitter on the other board.
- Synchronises and samples the serial line, checks the start bit, decodes 8 data bits MSB first and pushes each good byte into a first-word-fall-through FIFO.
- The host drains the FIFO via a read strobe; line status and error pulses go to the CPLD control logic.

---
 rtl/m_receiver.sv | 197 +++++++++++++++++++
 tb/tb_m_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_receiver.sv
// Manchester line receiver: synchronises the serial line, decodes start bit + 8 data
// bits (MSB first) and queues good bytes in a first-word-fall-through FIFO.
module m_receiver #(
    parameter int SAMPLES_PER_HALF = 4,
    parameter int DEPTH            = 16
) (
    input  logic       i_clk_2x,
    input  logic       i_rst,
    input  logic       i_m_rx,
    input  logic       i_data_re,
    output logic [7:0] o_data,
    output logic [7:0] o_data_count,
    output logic       o_m_status,
    output logic       o_err,
    output logic       o_overflow
);

    localparam int CNT_W = (SAMPLES_PER_HALF > 1) ? $clog2(SAMPLES_PER_HALF) : 1;
    localparam int LOW_W = $clog2(2 * SAMPLES_PER_HALF) + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(SAMPLES_PER_HALF / 2 - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SAMPLES_PER_HALF - 1);
    localparam logic [LOW_W-1:0] LOW_LAST  = LOW_W'(2 * SAMPLES_PER_HALF - 1);
    localparam logic [7:0]       DEPTH_CNT = 8'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START_H1 = 3'd1,
        S_START_H2 = 3'd2,
        S_DATA_H1  = 3'd3,
        S_DATA_H2  = 3'd4,
        S_STOP     = 3'd5
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    logic             w_rx_s;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_half_cnt;
    logic [LOW_W-1:0] r_low_cnt;
    logic             w_tick;
    logic             r_h1;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_push;
    logic             r_err;
    logic             r_overflow;
    logic             w_status;
    logic             w_viol;
    logic             w_shift_en;
    logic             w_byte_done;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [7:0]       r_count;
    logic             w_pop;
    logic             w_full;
    logic             w_wr;

    assign w_rx_s = r_sync2;
    assign w_tick = (r_half_cnt == SAMPLE_PT);

    always_ff @(posedge i_clk_2x) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_rx_prev <= 1'b0;
        end else begin
            r_sync1   <= i_m_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= w_rx_s;
        end
    end

    always_ff @(posedge i_clk_2x) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_rx_s && !r_rx_prev) w_next = S_START_H1;
            S_START_H1: if (w_tick) w_next = w_rx_s ? S_START_H2 : S_IDLE;
            S_START_H2: if (w_tick) w_next = w_rx_s ? S_STOP : S_DATA_H1;
            S_DATA_H1:  if (w_tick) w_next = S_DATA_H2;
            S_DATA_H2: begin
                if (w_tick) begin
                    if (r_h1 == w_rx_s || r_bit_idx == 3'd0) begin
                        w_next = S_STOP;
                    end else begin
                        w_next = S_DATA_H1;
                    end
                end
            end
            S_STOP:     if (!w_rx_s && r_low_cnt == LOW_LAST) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_status    = (r_state != S_IDLE);
        w_viol      = 1'b0;
        w_shift_en  = 1'b0;
        w_byte_done = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_START_H2: w_viol = w_rx_s;
                S_DATA_H2: begin
                    w_viol      = (r_h1 == w_rx_s);
                    w_shift_en  = (r_h1 != w_rx_s);
                    w_byte_done = (r_h1 != w_rx_s) && (r_bit_idx == 3'd0);
                end
                default: ;
            endcase
        end
    end

    // Sample timing is free-running from the start edge; no mid-frame resync.
    always_ff @(posedge i_clk_2x) begin
        if (i_rst || r_state == S_IDLE) begin
            r_half_cnt <= '0;
        end else if (r_half_cnt == HALF_LAST) begin
            r_half_cnt <= '0;
        end else begin
            r_half_cnt <= r_half_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk_2x) begin
        if (i_rst || r_state != S_STOP || w_rx_s) begin
            r_low_cnt <= '0;
        end else begin
            r_low_cnt <= r_low_cnt + LOW_W'(1);
        end
    end

    always_ff @(posedge i_clk_2x) begin
        if (i_rst) begin
            r_h1       <= 1'b0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_push     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_push <= w_byte_done;
            r_err  <= w_viol;
            if (r_state == S_START_H2 && w_tick) r_bit_idx <= 3'd7;
            if (r_state == S_DATA_H1 && w_tick) r_h1 <= w_rx_s;
            if (w_shift_en) begin
                r_shift <= {r_shift[6:0], r_h1};
                if (r_bit_idx != 3'd0) r_bit_idx <= r_bit_idx - 3'd1;
            end
        end
    end

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_pop  = i_data_re && (r_count != 8'd0);
    assign w_full = (r_count == DEPTH_CNT);
    assign w_wr   = r_push && (!w_full || w_pop);

    always_ff @(posedge i_clk_2x) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge i_clk_2x) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 8'd0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_push && w_full && !w_pop;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 8'd1;
                2'b01:   r_count <= r_count - 8'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data       = (r_count != 8'd0) ? r_mem[r_rd_ptr] : 8'h00;
    assign o_data_count = r_count;
    assign o_m_status   = w_status;
    assign o_err        = r_err;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_m_receiver.sv
// Bench for m_receiver: drives ideal Manchester frames cycle by cycle and compares
// against a byte-queue model of the decoder and FIFO.
module tb_m_receiver;

  localparam int SPH          = 4;
  localparam int DEPTH        = 16;
  localparam int FRAME_STEPS  = 18 * SPH;
  localparam int FIRST_SAMPLE = 2 + SPH / 2;
  localparam int LAST_SAMPLE  = FIRST_SAMPLE + 17 * SPH;
  localparam int PUSH_STEP    = LAST_SAMPLE + 1;

  logic       i_clk_2x;
  logic       i_rst;
  logic       i_m_rx;
  logic       i_data_re;
  logic [7:0] o_data;
  logic [7:0] o_data_count;
  logic       o_m_status;
  logic       o_err;
  logic       o_overflow;

  logic [7:0] exp_q[$];
  int         cyc;
  int         push_cyc;
  int         err_cyc;
  logic [7:0] push_byte;
  int         ovf_seen;
  int         n_checks;
  int         n_errors;

  m_receiver #(.SAMPLES_PER_HALF(SPH), .DEPTH(DEPTH)) dut (
    .i_clk_2x     (i_clk_2x),
    .i_rst        (i_rst),
    .i_m_rx       (i_m_rx),
    .i_data_re    (i_data_re),
    .o_data       (o_data),
    .o_data_count (o_data_count),
    .o_m_status   (o_m_status),
    .o_err        (o_err),
    .o_overflow   (o_overflow)
  );

  // clock / reset
  initial i_clk_2x = 1'b0;
  always #5 i_clk_2x = ~i_clk_2x;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ideal line level for step k of a frame; bad_pos forces a data bit high in both halves.
  function automatic logic line_val(input logic [7:0] d, input int bad_pos, input int k);
    int   h;
    int   p;
    logic b;
    h = k / SPH;
    if (h == 0) return 1'b1;
    if (h == 1) return 1'b0;
    p = (h - 2) / 2;
    if (p == bad_pos) return 1'b1;
    b = d[7 - p];
    return (((h - 2) % 2) == 0) ? b : ~b;
  endfunction

  // One clock of stimulus plus the model update for that edge.
  task automatic clk_step(input logic line, input logic re);
    logic do_pop;
    logic full;
    logic exp_ovf;
    logic exp_err;
    i_m_rx    = line;
    i_data_re = re;
    check("count", o_data_count, 32'(exp_q.size()));
    do_pop = re && (exp_q.size() != 0);
    if (do_pop) check("data", o_data, exp_q[0]);
    full = (exp_q.size() == DEPTH);
    @(posedge i_clk_2x);
    cyc++;
    exp_ovf = 1'b0;
    if (do_pop) void'(exp_q.pop_front());
    if (cyc == push_cyc) begin
      if (!full || do_pop) exp_q.push_back(push_byte);
      else exp_ovf = 1'b1;
    end
    exp_err = (cyc == err_cyc);
    #1;
    if (o_overflow === 1'b1) ovf_seen++;
    check("overflow", o_overflow, exp_ovf);
    check("err", o_err, exp_err);
    i_data_re = 1'b0;
  endtask

  task automatic do_reset();
    i_rst     = 1'b1;
    i_m_rx    = 1'b0;
    i_data_re = 1'b0;
    @(posedge i_clk_2x);
    cyc++;
    #1;
    i_rst = 1'b0;
    exp_q.delete();
    push_cyc = -1;
    err_cyc  = -1;
    check("rst_count", o_data_count, 0);
    check("rst_status", o_m_status, 0);
    check("rst_err", o_err, 0);
    check("rst_ovf", o_overflow, 0);
  endtask

  // driver: full frame plus gap idle steps; pops requested at steps pop0/pop1.
  task automatic send_frame(input logic [7:0] d, input int bad_pos, input int gap,
                            input int pop0, input int pop1);
    int base;
    int last_high;
    int fall;
    base = cyc + 1;
    last_high = 0;
    for (int k = 0; k < FRAME_STEPS; k++) if (line_val(d, bad_pos, k)) last_high = k;
    fall = last_high + 2 * SPH + 2;
    if (LAST_SAMPLE + 2 * SPH > fall) fall = LAST_SAMPLE + 2 * SPH;
    if (bad_pos < 0) begin
      push_cyc  = base + PUSH_STEP;
      push_byte = d;
    end else begin
      err_cyc = base + FIRST_SAMPLE + (3 + 2 * bad_pos) * SPH;
    end
    for (int k = 0; k < FRAME_STEPS + gap; k++) begin
      clk_step((k < FRAME_STEPS) ? line_val(d, bad_pos, k) : 1'b0, (k == pop0) || (k == pop1));
      if (k == 1) check("status_idle", o_m_status, 0);
      if (k == 2) check("status_rise", o_m_status, 1);
      if (bad_pos < 0 && k == fall - 1) check("status_hold", o_m_status, 1);
      if (bad_pos < 0 && k == fall) check("status_fall", o_m_status, 0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    push_cyc  = -1;
    err_cyc   = -1;
    ovf_seen  = 0;
    i_rst     = 1'b1;
    i_m_rx    = 1'b0;
    i_data_re = 1'b0;
    repeat (2) @(posedge i_clk_2x);
    do_reset();
    repeat (10) clk_step(1'b0, 1'b0);

    // single frame
    send_frame(8'hA5, -1, 12, -1, -1);
    check("head_a5", o_data, 8'hA5);
    check("count_1", o_data_count, 1);
    clk_step(1'b0, 1'b1);

    // back-to-back frames, one idle bit time apart
    send_frame(8'h00, -1, 2 * SPH, -1, -1);
    send_frame(8'hFF, -1, 2 * SPH, -1, -1);
    send_frame(8'h3C, -1, 12, -1, -1);
    check("count_3", o_data_count, 3);
    check("head_00", o_data, 8'h00);
    repeat (3) clk_step(1'b0, 1'b1);
    clk_step(1'b0, 1'b1);
    clk_step(1'b0, 1'b0);
    check("count_empty", o_data_count, 0);

    // violation on data bit 4 of 0x81, then a clean frame
    send_frame(8'h81, 7 - 4, 12, -1, -1);
    check("viol_count", o_data_count, 0);
    send_frame(8'h42, -1, 12, -1, -1);
    check("head_42", o_data, 8'h42);
    clk_step(1'b0, 1'b1);

    // glitch in idle
    clk_step(1'b1, 1'b0);
    clk_step(1'b0, 1'b0);
    clk_step(1'b0, 1'b0);
    check("glitch_detect", o_m_status, 1);
    for (int k = 3; k <= 2 * SPH; k++) clk_step(1'b0, 1'b0);
    check("glitch_idle", o_m_status, 0);
    repeat (4) clk_step(1'b0, 1'b0);

    // reset mid-frame with three bytes queued
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), -1, 12, -1, -1);
    check("pre_rst_count", o_data_count, 3);
    begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      for (int k = 0; k < 30; k++) clk_step(line_val(d, -1, k), 1'b0);
    end
    do_reset();
    repeat (4) clk_step(1'b0, 1'b0);
    send_frame(8'hA5, -1, 12, -1, -1);
    check("post_rst_a5", o_data, 8'hA5);
    clk_step(1'b0, 1'b1);

    // overflow: 17 frames into a 16-deep FIFO
    ovf_seen = 0;
    for (int i = 0; i <= 16; i++) send_frame(8'(i), -1, 10, -1, -1);
    check("full_count", o_data_count, DEPTH);
    check("ovf_pulses", ovf_seen, 1);
    check("full_head", o_data, 8'h00);

    // refill while reading: first frames pop exactly on the push edge at full
    for (int i = 0; i < 20; i++) begin
      int extra;
      extra = ((i >= 4) && (i % 2 == 1)) ? $urandom_range(0, FRAME_STEPS - 1) : -1;
      send_frame(8'($urandom_range(0, 255)), -1, $urandom_range(2 * SPH, 14), PUSH_STEP, extra);
      if (i == 3) check("full_pushpop", o_data_count, DEPTH);
    end
    check("ovf_refill", ovf_seen, 1);
    begin
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 64) begin
        clk_step(1'b0, 1'b1);
        guard++;
      end
    end
    clk_step(1'b0, 1'b1);
    clk_step(1'b0, 1'b0);
    check("drain_count", o_data_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
